// File: rtl/sdram_port_arbiter.sv
//------------------------------------------------------------------------------
// Module   : sdram_port_arbiter
// Brief    : Shares the SDRAM CPU port between fetch (I) and load/store (D).
//            Define SDRAM_ARB_PERF_EN to add saturating performance counters.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sdram_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 16
) (
    input  logic        cpu_clk,
    input  logic        reset_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_done,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic        d_done,
    output logic [31:0] d_rdata,
    output logic        mem_ren,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        owner
`ifdef SDRAM_ARB_PERF_EN
    ,
    output logic [CNT_W-1:0] perf_i_cnt,
    output logic [CNT_W-1:0] perf_d_cnt,
    output logic [CNT_W-1:0] perf_stall_cnt
`endif
);

    localparam logic [7:0] C_STARVE_MAX = 8'(STARVE_LIMIT);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_RESP      = 3'd4
    } state_t;

    state_t      state_q,      state_d;
    logic        owner_q,      owner_d;
    logic        we_q,         we_d;
    logic [31:0] mem_addr_q,   mem_addr_d;
    logic [31:0] mem_wdata_q,  mem_wdata_d;
    logic [3:0]  mem_be_q,     mem_be_d;
    logic [31:0] i_rdata_q,    i_rdata_d;
    logic [31:0] d_rdata_q,    d_rdata_d;
    logic [7:0]  starve_cnt_q, starve_cnt_d;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        we_d         = we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_be_d     = mem_be_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        starve_cnt_d = starve_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (mem_ready && (i_req || d_req)) begin
                    // D has priority unless I has watched STARVE_LIMIT D grants go by
                    if (i_req && (!d_req || (starve_cnt_q == C_STARVE_MAX))) begin
                        owner_d      = 1'b1;
                        we_d         = 1'b0;
                        mem_addr_d   = i_addr;
                        mem_wdata_d  = 32'h0;
                        mem_be_d     = 4'b1111;
                        starve_cnt_d = 8'd0;
                    end else begin
                        owner_d     = 1'b0;
                        we_d        = d_we;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                        mem_be_d    = d_be;
                        if (!i_req) begin
                            starve_cnt_d = 8'd0;
                        end else if (starve_cnt_q != C_STARVE_MAX) begin
                            starve_cnt_d = starve_cnt_q + 8'd1;
                        end
                    end
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (!mem_ready) begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (mem_ready) begin
                    // stores complete without disturbing the last load data
                    if (owner_q) begin
                        i_rdata_d = mem_rdata;
                    end else if (!we_q) begin
                        d_rdata_d = mem_rdata;
                    end
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge cpu_clk) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            owner_q      <= 1'b0;
            we_q         <= 1'b0;
            mem_addr_q   <= 32'h0;
            mem_wdata_q  <= 32'h0;
            mem_be_q     <= 4'h0;
            i_rdata_q    <= 32'h0;
            d_rdata_q    <= 32'h0;
            starve_cnt_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_be_q     <= mem_be_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign mem_ren   = (state_q == ST_ISSUE) && !we_q;
    assign mem_wen   = (state_q == ST_ISSUE) &&  we_q;
    assign i_done    = (state_q == ST_RESP)  &&  owner_q;
    assign d_done    = (state_q == ST_RESP)  && !owner_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign owner     = owner_q;

`ifdef SDRAM_ARB_PERF_EN
    logic [CNT_W-1:0] perf_i_cnt_q,     perf_i_cnt_d;
    logic [CNT_W-1:0] perf_d_cnt_q,     perf_d_cnt_d;
    logic [CNT_W-1:0] perf_stall_cnt_q, perf_stall_cnt_d;

    always_comb begin
        perf_i_cnt_d     = perf_i_cnt_q;
        perf_d_cnt_d     = perf_d_cnt_q;
        perf_stall_cnt_d = perf_stall_cnt_q;
        if (i_done && (perf_i_cnt_q != '1)) begin
            perf_i_cnt_d = perf_i_cnt_q + 1'b1;
        end
        if (d_done && (perf_d_cnt_q != '1)) begin
            perf_d_cnt_d = perf_d_cnt_q + 1'b1;
        end
        if ((i_req || d_req) && (state_q != ST_IDLE) && (perf_stall_cnt_q != '1)) begin
            perf_stall_cnt_d = perf_stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (!reset_n) begin
            perf_i_cnt_q     <= '0;
            perf_d_cnt_q     <= '0;
            perf_stall_cnt_q <= '0;
        end else begin
            perf_i_cnt_q     <= perf_i_cnt_d;
            perf_d_cnt_q     <= perf_d_cnt_d;
            perf_stall_cnt_q <= perf_stall_cnt_d;
        end
    end

    assign perf_i_cnt     = perf_i_cnt_q;
    assign perf_d_cnt     = perf_d_cnt_q;
    assign perf_stall_cnt = perf_stall_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sdram_port_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_sdram_port_arbiter
// Brief    : Scoreboard bench for sdram_port_arbiter with a simple SDRAM model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sdram_port_arbiter;

    logic        cpu_clk = 1'b0;
    logic        reset_n;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_done;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        owner;
`ifdef SDRAM_ARB_PERF_EN
    logic [15:0] perf_i_cnt;
    logic [15:0] perf_d_cnt;
    logic [15:0] perf_stall_cnt;
`endif

    always #5 cpu_clk = ~cpu_clk;

    sdram_port_arbiter #(
        .STARVE_LIMIT (4),
        .CNT_W        (16)
    ) dut (
        .cpu_clk   (cpu_clk),
        .reset_n   (reset_n),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_done    (i_done),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_be      (d_be),
        .d_done    (d_done),
        .d_rdata   (d_rdata),
        .mem_ren   (mem_ren),
        .mem_wen   (mem_wen),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .owner     (owner)
`ifdef SDRAM_ARB_PERF_EN
        ,
        .perf_i_cnt     (perf_i_cnt),
        .perf_d_cnt     (perf_d_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    typedef struct packed {
        logic        owner;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } txn_t;

    typedef struct packed {
        logic        owner;
        logic [31:0] rdata;
    } resp_t;

    txn_t        exp_txn_q[$];
    resp_t       exp_resp_q[$];
    logic [31:0] mdata_q[$];

    int   n_vec      = 0;
    int   n_fail     = 0;
    int   strobe_cnt = 0;
    int   i_done_cnt = 0;
    int   d_done_cnt = 0;
    int   busy_len   = 2;
    logic hold_low   = 1'b0;
    logic model_ready;

    assign mem_ready = model_ready && !hold_low;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic void fail_now(input string name);
        n_vec++;
        n_fail++;
        $display("FAIL %s: event not expected or not seen", name);
    endfunction

    task automatic expect_txn(input logic owner_e, input logic we_e, input logic [31:0] addr_e,
                              input logic [31:0] wdata_e, input logic [3:0] be_e,
                              input logic [31:0] mem_data, input logic [31:0] port_rdata,
                              input bit with_resp);
        txn_t  t;
        resp_t r;
        t.owner = owner_e;
        t.we    = we_e;
        t.addr  = addr_e;
        t.wdata = wdata_e;
        t.be    = be_e;
        exp_txn_q.push_back(t);
        mdata_q.push_back(mem_data);
        if (with_resp) begin
            r.owner = owner_e;
            r.rdata = port_rdata;
            exp_resp_q.push_back(r);
        end
    endtask

    // SDRAM interface model: drops ready after a strobe, holds it low busy_len cycles
    initial begin
        logic [31:0] data;
        model_ready = 1'b1;
        mem_rdata   = 32'h0;
        forever begin
            @(negedge cpu_clk);
            if (reset_n && (mem_ren || mem_wen)) begin
                model_ready = 1'b0;
                data = (mdata_q.size() != 0) ? mdata_q.pop_front() : 32'h0;
                repeat (busy_len) @(negedge cpu_clk);
                mem_rdata   = data;
                model_ready = 1'b1;
            end
        end
    end

    // Scoreboard monitor
    txn_t  mon_t;
    resp_t mon_r;
    always @(negedge cpu_clk) begin
        if (mem_ren || mem_wen) begin
            strobe_cnt++;
            check("dual_strobe", {31'b0, mem_ren & mem_wen}, 32'h0);
            if (exp_txn_q.size() == 0) begin
                fail_now("unexpected_strobe");
            end else begin
                mon_t = exp_txn_q.pop_front();
                check("strobe_kind",  {31'b0, mem_wen}, {31'b0, mon_t.we});
                check("strobe_addr",  mem_addr,  mon_t.addr);
                check("strobe_wdata", mem_wdata, mon_t.wdata);
                check("strobe_be",    {28'b0, mem_be}, {28'b0, mon_t.be});
                check("strobe_owner", {31'b0, owner},  {31'b0, mon_t.owner});
            end
        end
        if (i_done || d_done) begin
            if (i_done) i_done_cnt++;
            if (d_done) d_done_cnt++;
            check("dual_done", {31'b0, i_done & d_done}, 32'h0);
            if (exp_resp_q.size() == 0) begin
                fail_now("unexpected_done");
            end else begin
                mon_r = exp_resp_q.pop_front();
                check("done_port",  {31'b0, i_done}, {31'b0, mon_r.owner});
                check("done_owner", {31'b0, owner},  {31'b0, mon_r.owner});
                check("done_rdata", mon_r.owner ? i_rdata : d_rdata, mon_r.rdata);
            end
        end
    end

    task automatic wait_i_done();
        for (int k = 0; k < 200; k++) begin
            @(negedge cpu_clk);
            if (i_done) return;
        end
        fail_now("i_done_timeout");
    endtask

    task automatic wait_d_done();
        for (int k = 0; k < 200; k++) begin
            @(negedge cpu_clk);
            if (d_done) return;
        end
        fail_now("d_done_timeout");
    endtask

    task automatic do_i(input logic [31:0] addr);
        i_addr = addr;
        i_req  = 1'b1;
        wait_i_done();
        i_req  = 1'b0;
    endtask

    // n back-to-back D accesses with d_req held high across each done
    task automatic do_d(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input int n);
        for (int k = 0; k < n; k++) begin
            d_we    = we;
            d_addr  = addr + 32'(4 * k);
            d_wdata = wdata;
            d_be    = be;
            d_req   = 1'b1;
            wait_d_done();
        end
        d_req = 1'b0;
    endtask

    initial begin
        int base;
        int dn;
        reset_n = 1'b0;
        i_req   = 1'b0;
        i_addr  = 32'h0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = 32'h0;
        d_wdata = 32'h0;
        d_be    = 4'h0;
        repeat (3) @(negedge cpu_clk);
        check("rst_strobe_done", {28'b0, mem_ren, mem_wen, i_done, d_done}, 32'h0);
        check("rst_addr",        mem_addr, 32'h0);
        check("rst_be_owner",    {27'b0, mem_be, owner}, 32'h0);
        check("rst_rdata",       i_rdata | d_rdata, 32'h0);
        reset_n = 1'b1;
        @(negedge cpu_clk);

        // single fetch
        expect_txn(1'b1, 1'b0, 32'h100, 32'h0, 4'hF, 32'hDEADBEEF, 32'hDEADBEEF, 1);
        do_i(32'h100);
        check("t1_i_rdata",    i_rdata, 32'hDEADBEEF);
        check("t1_no_d_done",  32'(d_done_cnt), 32'd0);
        check("t1_one_strobe", 32'(strobe_cnt), 32'd1);
        @(negedge cpu_clk);

        // simultaneous requests: D first, then I
        expect_txn(1'b0, 1'b0, 32'h700, 32'h0, 4'hF, 32'hCAFEF00D, 32'hCAFEF00D, 1);
        expect_txn(1'b1, 1'b0, 32'h104, 32'h0, 4'hF, 32'h11112222, 32'h11112222, 1);
        fork
            do_d(1'b0, 32'h700, 32'h0, 4'hF, 1);
            do_i(32'h104);
        join
        check("t3_d_rdata", d_rdata, 32'hCAFEF00D);
        check("t3_i_rdata", i_rdata, 32'h11112222);
        @(negedge cpu_clk);

        // store leaves d_rdata alone
        expect_txn(1'b0, 1'b1, 32'h200, 32'h12345678, 4'b0011, 32'hBAD0BAD0, 32'hCAFEF00D, 1);
        do_d(1'b1, 32'h200, 32'h12345678, 4'b0011, 1);
        check("t2_d_rdata_held", d_rdata, 32'hCAFEF00D);
        @(negedge cpu_clk);

        // starvation: four D grants, then I forced, then D resumes
        for (int k = 0; k < 4; k++) begin
            expect_txn(1'b0, 1'b0, 32'h500 + 32'(4 * k), 32'h0, 4'hF,
                       32'hD0000000 + 32'(k), 32'hD0000000 + 32'(k), 1);
        end
        expect_txn(1'b1, 1'b0, 32'h400, 32'h0, 4'hF, 32'h1A1A1A1A, 32'h1A1A1A1A, 1);
        expect_txn(1'b0, 1'b0, 32'h510, 32'h0, 4'hF, 32'hD0000004, 32'hD0000004, 1);
        fork
            do_i(32'h400);
            do_d(1'b0, 32'h500, 32'h0, 4'hF, 5);
        join
        check("t4_d_rdata", d_rdata, 32'hD0000004);
        check("t4_i_rdata", i_rdata, 32'h1A1A1A1A);
        @(negedge cpu_clk);

        // reset during WAIT_DONE abandons the fetch
        busy_len = 8;
        base = strobe_cnt;
        expect_txn(1'b1, 1'b0, 32'h300, 32'h0, 4'hF, 32'h33333333, 32'h0, 0);
        i_addr = 32'h300;
        i_req  = 1'b1;
        for (int k = 0; k < 20 && strobe_cnt == base; k++) @(negedge cpu_clk);
        check("t5_strobe_seen", 32'(strobe_cnt), 32'(base + 1));
        repeat (2) @(negedge cpu_clk);
        reset_n = 1'b0;
        i_req   = 1'b0;
        @(negedge cpu_clk);
        check("t5_rst_strobe_done", {28'b0, mem_ren, mem_wen, i_done, d_done}, 32'h0);
        check("t5_rst_rdata", i_rdata, 32'h0);
        dn = i_done_cnt + d_done_cnt;
        reset_n = 1'b1;
        repeat (12) @(negedge cpu_clk);
        check("t5_no_done_after_reset", 32'(i_done_cnt + d_done_cnt), 32'(dn));
        busy_len = 2;

        // interface not ready in IDLE: no strobe until it is
        hold_low = 1'b1;
        base = strobe_cnt;
        expect_txn(1'b0, 1'b0, 32'h600, 32'h0, 4'h5, 32'h66666666, 32'h66666666, 1);
        d_we   = 1'b0;
        d_addr = 32'h600;
        d_be   = 4'h5;
        d_req  = 1'b1;
        repeat (6) @(negedge cpu_clk);
        check("t6_no_strobe_while_busy", 32'(strobe_cnt), 32'(base));
        hold_low = 1'b0;
        wait_d_done();
        d_req = 1'b0;
        check("t6_d_rdata", d_rdata, 32'h66666666);
        repeat (3) @(negedge cpu_clk);

        check("txn_queue_drained",  32'(exp_txn_q.size()),  32'd0);
        check("resp_queue_drained", 32'(exp_resp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
